// File: rtl/alu_issue_buf.sv
// Issue buffer feeding the alu: two-entry skid FIFO that forms ALU_Op1/ALU_Op2 at accept.
// Optional build macro ALU_ISSUE_FWD_EN enables writeback forwarding onto the source operands.
module alu_issue_buf #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [WIDTH-1:0]  rs1_data,
    input  logic [WIDTH-1:0]  rs2_data,
    input  logic [WIDTH-1:0]  imm,
    input  logic              ALUsrc,
    input  logic [CTRL_W-1:0] ALUctrl_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic              fwd_valid,
    input  logic [ADDR_W-1:0] fwd_rd,
    input  logic [WIDTH-1:0]  fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  ALU_Op1,
    output logic [WIDTH-1:0]  ALU_Op2,
    output logic [CTRL_W-1:0] ALUctrl,
    output logic [ADDR_W-1:0] rd_out
);

    localparam int PW = 2 * WIDTH + CTRL_W + ADDR_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [PW-1:0]     head_r;
    logic [PW-1:0]     skid_r;
    logic [PW-1:0]     new_s;
    logic              out_valid_r;
    logic              in_ready_r;
    logic              accept_s;
    logic              consume_s;
    logic              head_new_s;
    logic              head_skid_s;
    logic              skid_new_s;
    logic [WIDTH-1:0]  src1_s;
    logic [WIDTH-1:0]  src2_s;
    logic [WIDTH-1:0]  op2_s;

    assign accept_s  = in_valid & in_ready_r;
    assign consume_s = out_valid_r & out_ready;

`ifndef ALU_ISSUE_FWD_EN
    logic unused_fwd_s;
    assign unused_fwd_s = ^{fwd_valid, fwd_rd, fwd_data, rs1_addr, rs2_addr};
`endif

    // Source operand resolution and Op2 mux for the incoming op
    always_comb begin
        src1_s = rs1_data;
        src2_s = rs2_data;
        op2_s  = rs2_data;
`ifdef ALU_ISSUE_FWD_EN
        // Register x0 is hardwired, so a writeback to it never forwards.
        if (fwd_valid && (fwd_rd == rs1_addr) && (rs1_addr != {ADDR_W{1'b0}})) begin
            src1_s = fwd_data;
        end else begin
            src1_s = rs1_data;
        end
        if (fwd_valid && (fwd_rd == rs2_addr) && (rs2_addr != {ADDR_W{1'b0}})) begin
            src2_s = fwd_data;
        end else begin
            src2_s = rs2_data;
        end
`endif
        if (ALUsrc) begin
            op2_s = imm;
        end else begin
            op2_s = src2_s;
        end
    end

    assign new_s = {src1_s, op2_s, ALUctrl_in, rd_in};

    // Next-state logic; flush overrides any accept or consume
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: state_s = accept_s ? ST_ONE : ST_EMPTY;
                ST_ONE: begin
                    if (accept_s && !consume_s) begin
                        state_s = ST_FULL;
                    end else if (!accept_s && consume_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL:  state_s = consume_s ? ST_ONE : ST_FULL;
                default:  state_s = ST_EMPTY;
            endcase
        end
    end

    // Payload load enables derived from the current state
    always_comb begin
        head_new_s  = 1'b0;
        head_skid_s = 1'b0;
        skid_new_s  = 1'b0;
        if (flush) begin
            head_new_s  = 1'b0;
            head_skid_s = 1'b0;
            skid_new_s  = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: head_new_s = accept_s;
                ST_ONE: begin
                    head_new_s = accept_s & consume_s;
                    skid_new_s = accept_s & ~consume_s;
                end
                ST_FULL:  head_skid_s = consume_s;
                default: begin
                    head_new_s  = 1'b0;
                    head_skid_s = 1'b0;
                    skid_new_s  = 1'b0;
                end
            endcase
        end
    end

    // State register with registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s != ST_EMPTY);
            in_ready_r  <= (state_s != ST_FULL);
        end
    end

    // Head and skid payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= {PW{1'b0}};
            skid_r <= {PW{1'b0}};
        end else begin
            if (head_new_s) begin
                head_r <= new_s;
            end else if (head_skid_s) begin
                head_r <= skid_r;
            end else begin
                head_r <= head_r;
            end
            if (skid_new_s) begin
                skid_r <= new_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;
    assign {ALU_Op1, ALU_Op2, ALUctrl, rd_out} = head_r;

endmodule

// File: tb/tb_alu_issue_buf.sv
// Self-checking bench for alu_issue_buf: directed vector table, reset/forwarding sequences,
// and random traffic checked against a queue-based reference model.
module tb_alu_issue_buf;

    logic        clk, rst_n, flush, in_valid, in_ready;
    logic [4:0]  rs1_addr, rs2_addr, rd_in, fwd_rd, rd_out;
    logic [31:0] rs1_data, rs2_data, imm, fwd_data, ALU_Op1, ALU_Op2;
    logic        ALUsrc, fwd_valid, out_valid, out_ready;
    logic [2:0]  ALUctrl_in, ALUctrl;

    int errors = 0;
    int checks = 0;

    alu_issue_buf #(.WIDTH(32), .CTRL_W(3), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .ALUsrc(ALUsrc), .ALUctrl_in(ALUctrl_in), .rd_in(rd_in),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .ALU_Op1(ALU_Op1), .ALU_Op2(ALU_Op2),
        .ALUctrl(ALUctrl), .rd_out(rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush, in_valid, out_ready, alusrc, fwd_valid;
        logic [4:0]  rs1a, rs2a, rd, fwd_rd;
        logic [31:0] rs1d, rs2d, imm, fwd_data;
        logic [2:0]  ctrl;
    } stim_t;

    typedef struct {
        logic [31:0] op1, op2;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        stim_t       s;
        logic        e_valid, e_ready;
        logic [31:0] e_op1, e_op2;
    } vec_t;

    op_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle(input logic ordy);
        stim_t s;
        s = '{flush: 1'b0, in_valid: 1'b0, out_ready: ordy, alusrc: 1'b0, fwd_valid: 1'b0,
              rs1a: 5'd0, rs2a: 5'd0, rd: 5'd0, fwd_rd: 5'd0, rs1d: 32'd0, rs2d: 32'd0,
              imm: 32'd0, fwd_data: 32'd0, ctrl: 3'd0};
        return s;
    endfunction

    function automatic vec_t mk(input logic fl, input logic iv, input logic ordy, input logic as,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                                input logic [2:0] c, input logic [4:0] d, input logic ev,
                                input logic er, input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.s = idle(ordy);
        v.s.flush = fl; v.s.in_valid = iv; v.s.alusrc = as;
        v.s.rs1d = a; v.s.rs2d = b; v.s.imm = im; v.s.ctrl = c; v.s.rd = d;
        v.e_valid = ev; v.e_ready = er; v.e_op1 = e1; v.e_op2 = e2;
        return v;
    endfunction

    // Reference: the op the alu should see for a given decode presentation
    function automatic op_t ref_op(input stim_t s);
        op_t o;
        logic [31:0] s1, s2;
        s1 = s.rs1d;
        s2 = s.rs2d;
`ifdef ALU_ISSUE_FWD_EN
        if (s.fwd_valid && s.fwd_rd == s.rs1a && s.rs1a != 5'd0) s1 = s.fwd_data;
        if (s.fwd_valid && s.fwd_rd == s.rs2a && s.rs2a != 5'd0) s2 = s.fwd_data;
`endif
        o.op1 = s1;
        o.op2 = s.alusrc ? s.imm : s2;
        o.ctrl = s.ctrl;
        o.rd = s.rd;
        return o;
    endfunction

    task automatic drive(input stim_t s);
        flush = s.flush; in_valid = s.in_valid; out_ready = s.out_ready; ALUsrc = s.alusrc;
        rs1_addr = s.rs1a; rs2_addr = s.rs2a; rd_in = s.rd; rs1_data = s.rs1d;
        rs2_data = s.rs2d; imm = s.imm; ALUctrl_in = s.ctrl;
        fwd_valid = s.fwd_valid; fwd_rd = s.fwd_rd; fwd_data = s.fwd_data;
    endtask

    task automatic model_chk();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() != 0) begin
            chk("op1", ALU_Op1, q[0].op1);
            chk("op2", ALU_Op2, q[0].op2);
            chk("ctrl", 32'(ALUctrl), 32'(q[0].ctrl));
            chk("rd", 32'(rd_out), 32'(q[0].rd));
        end
    endtask

    // Called at a negedge: apply, check against model, advance model over the posedge, return at next negedge
    task automatic step(input stim_t s);
        bit m_acc, m_con;
        drive(s);
        model_chk();
        m_acc = s.in_valid && (q.size() < 2);
        m_con = s.out_ready && (q.size() != 0);
        @(posedge clk);
        if (s.flush) begin
            q.delete();
        end else begin
            if (m_con) q.delete(0);
            if (m_acc) q.push_back(ref_op(s));
        end
        @(negedge clk);
    endtask

    vec_t  tbl[17];
    stim_t s;

    initial begin
        rst_n = 1'b0;
        drive(idle(1'b0));
        tbl[0]  = mk(0,1,1,0, 32'd5, 32'd7, 32'd0, 3'd0, 5'd1, 0,1, 32'd0, 32'd0);
        tbl[1]  = mk(0,1,1,1, 32'd5, 32'd7, 32'hFFFFFFFC, 3'd1, 5'd2, 1,1, 32'd5, 32'd7);
        tbl[2]  = mk(0,0,1,0, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0, 1,1, 32'd5, 32'hFFFFFFFC);
        tbl[3]  = mk(0,1,0,0, 32'h11, 32'h22, 32'd0, 3'd2, 5'd3, 0,1, 32'd0, 32'd0);
        tbl[4]  = mk(0,1,0,1, 32'h33, 32'hDEAD, 32'h44, 3'd3, 5'd4, 1,1, 32'h11, 32'h22);
        tbl[5]  = mk(0,1,0,0, 32'hC1, 32'hC2, 32'd0, 3'd4, 5'd5, 1,0, 32'h11, 32'h22);
        tbl[6]  = mk(0,0,1,0, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0, 1,0, 32'h11, 32'h22);
        tbl[7]  = mk(0,0,1,0, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0, 1,1, 32'h33, 32'h44);
        tbl[8]  = mk(0,1,0,0, 32'h55, 32'h66, 32'd0, 3'd5, 5'd6, 0,1, 32'd0, 32'd0);
        tbl[9]  = mk(0,1,0,0, 32'h77, 32'h88, 32'd0, 3'd6, 5'd7, 1,1, 32'h55, 32'h66);
        tbl[10] = mk(1,1,0,0, 32'h99, 32'hAA, 32'd0, 3'd7, 5'd8, 1,0, 32'h55, 32'h66);
        tbl[11] = mk(0,0,0,0, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0, 0,1, 32'd0, 32'd0);
        tbl[12] = mk(0,1,0,0, 32'h12, 32'h34, 32'd0, 3'd1, 5'd9, 0,1, 32'd0, 32'd0);
        tbl[13] = mk(1,1,1,0, 32'hAB, 32'hCD, 32'd0, 3'd2, 5'd10, 1,1, 32'h12, 32'h34);
        tbl[14] = mk(0,0,1,0, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0, 0,1, 32'd0, 32'd0);
        tbl[15] = mk(0,1,1,0, 32'hE0, 32'hF0, 32'd0, 3'd3, 5'd11, 0,1, 32'd0, 32'd0);
        tbl[16] = mk(0,0,1,0, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0, 1,1, 32'hE0, 32'hF0);

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_op1", ALU_Op1, 32'd0);
        chk("rst_op2", ALU_Op2, 32'd0);
        chk("rst_ctrl", 32'(ALUctrl), 32'd0);
        chk("rst_rd", 32'(rd_out), 32'd0);
        rst_n = 1'b1;

        // Directed table: streaming, backpressure, flush
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].s);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_ready));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_op1", i), ALU_Op1, tbl[i].e_op1);
                chk($sformatf("tbl%0d_op2", i), ALU_Op2, tbl[i].e_op2);
            end
            step(tbl[i].s);
        end

        // Forwarding on rs1, then the x0 exclusion
        s = idle(1'b1);
        s.in_valid = 1'b1; s.rs1a = 5'd3; s.rs1d = 32'd1; s.rs2d = 32'd9;
        s.fwd_valid = 1'b1; s.fwd_rd = 5'd3; s.fwd_data = 32'h55;
        step(s);
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_op1_hit", ALU_Op1, 32'h55);
`else
        chk("fwd_op1_off", ALU_Op1, 32'd1);
`endif
        s.rs1a = 5'd0; s.fwd_rd = 5'd0; s.rs1d = 32'd2;
        step(s);
        chk("fwd_op1_x0", ALU_Op1, 32'd2);
        step(idle(1'b1));

        // Reset mid-stream with both entries occupied
        s = idle(1'b0);
        s.in_valid = 1'b1; s.rs1d = 32'hA1; s.rs2d = 32'hA2;
        step(s);
        s.rs1d = 32'hB1; s.rs2d = 32'hB2;
        step(s);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_op1", ALU_Op1, 32'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(idle(1'b1));

        // Random traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            s.flush     = ($urandom_range(0, 15) == 0);
            s.in_valid  = ($urandom_range(0, 3) != 0);
            s.out_ready = ($urandom_range(0, 2) != 0);
            s.alusrc    = 1'($urandom_range(0, 1));
            s.fwd_valid = 1'($urandom_range(0, 1));
            s.rs1a      = 5'($urandom_range(0, 3));
            s.rs2a      = 5'($urandom_range(0, 3));
            s.fwd_rd    = 5'($urandom_range(0, 3));
            s.rd        = 5'($urandom);
            s.ctrl      = 3'($urandom);
            s.rs1d      = $urandom;
            s.rs2d      = $urandom;
            s.imm       = $urandom;
            s.fwd_data  = $urandom;
            step(s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
